// File: rtl/accelerator_tensor_fixed_streamer_pkg.sv
// accelerator_tensor_fixed_streamer_pkg: shared constants for the tensor streamer and collector.
// Holds the FSM state encoding, the ZERO/ONE constants and the tag record that the
// read pipeline carries alongside each in-flight memory read.
package accelerator_tensor_fixed_streamer_pkg;
  localparam logic [1:0] STARTER     = 2'd0;
  localparam logic [1:0] ISSUE_STATE = 2'd1;
  localparam logic [1:0] DRAIN_STATE = 2'd2;
  localparam int ZERO = 0;
  localparam int ONE  = 1;
  typedef struct packed {
    logic first_slice;
    logic first_row;
  } tag_t;
endpackage

// File: rtl/accelerator_tensor_index_counter.sv
// accelerator_tensor_index_counter: nested i/j/k wrap counters with position flags.
// Ports: CLK/RST (sync, active-low), load_i clears all indices, en_i advances k
// (wrapping into j, then i), size_*_i are the wrap limits, first_row_o (k==0),
// first_slice_o (j==0 && k==0), last_o (all indices at size-1).
module accelerator_tensor_index_counter
  import accelerator_tensor_fixed_streamer_pkg::*;
#(
  parameter int CONTROL_SIZE = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    load_i,
  input  logic                    en_i,
  input  logic [CONTROL_SIZE-1:0] size_i_i,
  input  logic [CONTROL_SIZE-1:0] size_j_i,
  input  logic [CONTROL_SIZE-1:0] size_k_i,
  output logic                    first_row_o,
  output logic                    first_slice_o,
  output logic                    last_o
);
  localparam logic [CONTROL_SIZE-1:0] C_ZERO = CONTROL_SIZE'(ZERO);
  localparam logic [CONTROL_SIZE-1:0] C_ONE  = CONTROL_SIZE'(ONE);
  logic [CONTROL_SIZE-1:0] i_q, j_q, k_q, i_d, j_d, k_d;
  logic i_end, j_end, k_end;
  assign i_end = i_q == size_i_i - C_ONE;
  assign j_end = j_q == size_j_i - C_ONE;
  assign k_end = k_q == size_k_i - C_ONE;
  assign first_row_o   = k_q == C_ZERO;
  assign first_slice_o = first_row_o && j_q == C_ZERO;
  assign last_o        = i_end && j_end && k_end;
  always_comb begin
    k_d = load_i ? C_ZERO : en_i ? (k_end ? C_ZERO : k_q + C_ONE) : k_q;
    j_d = load_i ? C_ZERO : en_i && k_end ? (j_end ? C_ZERO : j_q + C_ONE) : j_q;
    i_d = load_i ? C_ZERO : en_i && k_end && j_end ? (i_end ? C_ZERO : i_q + C_ONE) : i_q;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      i_q <= C_ZERO;
      j_q <= C_ZERO;
      k_q <= C_ZERO;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end
endmodule

// File: rtl/accelerator_tensor_fixed_streamer.sv
// accelerator_tensor_fixed_streamer: walks a row-major I x J x K tensor in memory and streams it out.
// Ports: CLK/RST (sync, active-low); START latches sizes and base, READY pulses on completion;
// HOLD_IN stalls read issue; MEM_READ_OUT/MEM_ADDR_OUT issue reads, MEM_DATA_IN returns one
// cycle later; DATA_OUT carries each element with DATA_OUT_{I,J,K}_ENABLE position strobes.
module accelerator_tensor_fixed_streamer
  import accelerator_tensor_fixed_streamer_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 HOLD_IN,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] SIZE_K_IN,
  input  logic [DATA_SIZE-1:0] BASE_ADDR_IN,
  output logic                 MEM_READ_OUT,
  output logic [DATA_SIZE-1:0] MEM_ADDR_OUT,
  input  logic [DATA_SIZE-1:0] MEM_DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 DATA_OUT_I_ENABLE,
  output logic                 DATA_OUT_J_ENABLE,
  output logic                 DATA_OUT_K_ENABLE
);
  localparam logic [DATA_SIZE-1:0] D_ZERO = DATA_SIZE'(ZERO);
  localparam logic [DATA_SIZE-1:0] D_ONE  = DATA_SIZE'(ONE);
  logic [1:0] state_q, state_d;
  logic [CONTROL_SIZE-1:0] size_i_q, size_j_q, size_k_q;
  logic [DATA_SIZE-1:0] base_q, off_q, off_d, data_q;
  tag_t tag_q;
  logic rd_q, ready_q;
  logic load, issue, zero, first_row, first_slice, last;
  // Only the low CONTROL_SIZE bits of each size are meaningful; the rest are dropped.
  logic unused_size_bits;
  assign unused_size_bits = ^{SIZE_I_IN[DATA_SIZE-1:CONTROL_SIZE], SIZE_J_IN[DATA_SIZE-1:CONTROL_SIZE],
                              SIZE_K_IN[DATA_SIZE-1:CONTROL_SIZE]};
  assign zero  = ~|SIZE_I_IN[CONTROL_SIZE-1:0] || ~|SIZE_J_IN[CONTROL_SIZE-1:0] ||
                 ~|SIZE_K_IN[CONTROL_SIZE-1:0];
  assign load  = state_q == STARTER && START;
  assign issue = state_q == ISSUE_STATE && !HOLD_IN;
  accelerator_tensor_index_counter #(.CONTROL_SIZE(CONTROL_SIZE)) u_index (
    .CLK          (CLK),
    .RST          (RST),
    .load_i       (load),
    .en_i         (issue),
    .size_i_i     (size_i_q),
    .size_j_i     (size_j_q),
    .size_k_i     (size_k_q),
    .first_row_o  (first_row),
    .first_slice_o(first_slice),
    .last_o       (last)
  );
  always_comb begin
    state_d = load ? (zero ? STARTER : ISSUE_STATE) :
              issue && last ? DRAIN_STATE :
              state_q == DRAIN_STATE ? STARTER : state_q;
    off_d   = load ? D_ZERO : issue ? off_q + D_ONE : off_q;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= STARTER;
      size_i_q <= '0;
      size_j_q <= '0;
      size_k_q <= '0;
      base_q   <= D_ZERO;
      off_q    <= D_ZERO;
      data_q   <= D_ZERO;
      tag_q    <= '0;
      rd_q     <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      rd_q    <= issue;
      ready_q <= (load && zero) || (issue && last);
      if (load) begin
        size_i_q <= SIZE_I_IN[CONTROL_SIZE-1:0];
        size_j_q <= SIZE_J_IN[CONTROL_SIZE-1:0];
        size_k_q <= SIZE_K_IN[CONTROL_SIZE-1:0];
        base_q   <= BASE_ADDR_IN;
      end
      // Tags ride one cycle behind the read so they line up with the returned data.
      if (issue) tag_q <= '{first_slice: first_slice, first_row: first_row};
      if (rd_q) data_q <= MEM_DATA_IN;
    end
  end
  assign MEM_READ_OUT      = issue;
  assign MEM_ADDR_OUT      = base_q + off_q;
  // Returned data passes straight through; data_q only keeps it visible between elements.
  assign DATA_OUT          = rd_q ? MEM_DATA_IN : data_q;
  assign DATA_OUT_K_ENABLE = rd_q;
  assign DATA_OUT_J_ENABLE = rd_q && tag_q.first_row;
  assign DATA_OUT_I_ENABLE = rd_q && tag_q.first_slice;
  assign READY             = ready_q;
endmodule

// File: doc/accelerator_tensor_fixed_streamer.md
# accelerator_tensor_fixed_streamer

Upstream feeder for the tensor fixed multiplier. On START it walks an I×J×K tensor stored row-major in a word-addressed memory, issues one read per element, and emits each element on DATA_OUT with the I/J/K enable strobes that the tensor arithmetic blocks consume. One instance drives each of DATA_A_IN and DATA_B_IN of the multiplier.

## Interface
Parameters:
- DATA_SIZE, 64, data, size and address width
- CONTROL_SIZE, 4, index counter width; sizes use only their low CONTROL_SIZE bits

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-low
- START  in  1  one-cycle pulse; latches sizes and base address
- READY  out  1  one-cycle pulse on completion
- HOLD_IN  in  1  consumer back-pressure; no new read issued while high
- SIZE_I_IN, SIZE_J_IN, SIZE_K_IN  in  DATA_SIZE  tensor dimensions
- BASE_ADDR_IN  in  DATA_SIZE  address of element (0,0,0)
- MEM_READ_OUT  out  1  read strobe
- MEM_ADDR_OUT  out  DATA_SIZE  read address
- MEM_DATA_IN  in  DATA_SIZE  read data, valid exactly one cycle after MEM_READ_OUT
- DATA_OUT  out  DATA_SIZE  element value
- DATA_OUT_I_ENABLE  out  1  first element of an I slice (j=0,k=0)
- DATA_OUT_J_ENABLE  out  1  first element of a row (k=0)
- DATA_OUT_K_ENABLE  out  1  every valid element

## Operation
- States: STARTER (idle), ISSUE_STATE, DRAIN_STATE.
- STARTER: on START latch sizes (low CONTROL_SIZE bits) and base; clear i,j,k and address counter. If any latched size is 0 -> pulse READY next cycle, stay STARTER, no reads. Else -> ISSUE_STATE.
- ISSUE_STATE, HOLD_IN low: MEM_READ_OUT=1, MEM_ADDR_OUT=base+linear offset; record (j==0&&k==0, k==0) tags in a one-deep pipeline register; advance k, wrapping to 0 and incrementing j at SIZE_K-1; j wraps at SIZE_J-1 incrementing i. Read of (SIZE_I-1,SIZE_J-1,SIZE_K-1) -> DRAIN_STATE.
- ISSUE_STATE, HOLD_IN high: MEM_READ_OUT=0, counters frozen; an in-flight read still completes and is output.
- One cycle after each read: DATA_OUT=MEM_DATA_IN, K enable=1, J/I enables from tags.
- DRAIN_STATE: last element output that cycle with READY=1 -> STARTER.
- START outside STARTER is ignored.
- Address counter increments by 1 per issued read; modulo 2^DATA_SIZE wrap, no error.
- Enables and READY are pulses; DATA_OUT holds its last value when enables are low.

## Timing
- Reset (RST=0 at an edge): state STARTER, READY=0, MEM_READ_OUT=0, MEM_ADDR_OUT=0, DATA_OUT=0, all enables 0, counters 0. Reset mid-operation aborts; in-flight data is discarded, no READY.
- START at cycle 0, no hold: read n at cycle 1+n, output n at cycle 2+n, N=I·J·K elements, READY at cycle N+1 coincident with the last DATA_OUT_K_ENABLE.
- Each HOLD_IN-high cycle in ISSUE_STATE adds exactly one cycle to latency.
- HOLD_IN is ignored in STARTER and DRAIN_STATE.
- Zero-size START: READY at cycle 1, no MEM_READ_OUT or enables.
- Maximum throughput one element per cycle.

## Structure
- Shared NTM accelerator package: state encoding (STARTER/ISSUE/DRAIN), ZERO/ONE control and data constants.
- One sub-module: accelerator_tensor_index_counter (three nested wrap counters with load, enable, and first-of-row/first-of-slice/last flags); reusable by the downstream collector.
- Address counter, tag pipeline register and FSM live in the top module.

## Test plan
- I=J=K=2, base 0x10, memory[a]=a, no hold -> reads 0x10..0x17 on cycles 1..8; DATA_OUT 0x10..0x17 on cycles 2..9; I enables at 0x10,0x14; J enables at 0x10,0x12,0x14,0x16; READY cycle 9.
- I=1,J=2,K=3, HOLD_IN high cycles 3–4 -> six reads, outputs stall two cycles, READY cycle 9; no duplicate or lost element.
- SIZE_J=0 -> READY cycle 1, MEM_READ_OUT never asserted.
- RST low at cycle 4 of a 2×2×2 run -> all outputs 0 next cycle, no READY; new START runs fully correct.
- Base 0xFFFF_FFFF_FFFF_FFFE, I=J=1,K=4 -> addresses …FFFE, …FFFF, 0x0, 0x1.
- START pulsed at cycle 3 during a busy 1×1×4 run -> ignored; READY only at cycle 5.
